// File: rtl/ram_stream_reader.sv
// Read-side sequencer for the Jacobi matrix buffer RAM: reads a wrapping block of
// words through a one-cycle-latency RAM port and streams them out via a 2-entry buffer.
module ram_stream_reader #(
    parameter int ADDR_WIDTH = 7,
    parameter int MEM_SIZE   = 128,
    parameter int DATA_WIDTH = 20,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [LEN_WIDTH-1:0]   issue_cnt_r, pop_cnt_r;
    logic [ADDR_WIDTH-1:0]  ram_addr_r;
    logic                   pend_r, pend_last_r;
    logic                   head_valid_r, head_last_r, skid_valid_r, skid_last_r;
    logic [DATA_WIDTH-1:0]  head_data_r, skid_data_r;
    logic                   pop_s, issue_s, accept_s;
    logic [2:0]             load_s;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        if (a == ADDR_WIDTH'(MEM_SIZE - 1)) begin
            return {ADDR_WIDTH{1'b0}};
        end else begin
            return a + ADDR_WIDTH'(1);
        end
    endfunction

    assign pop_s  = head_valid_r & out_ready;
    // Words buffered plus the one arriving from the RAM this cycle.
    assign load_s = {2'b00, head_valid_r} + {2'b00, skid_valid_r} + {2'b00, pend_r};
    assign accept_s = (state_r == ST_IDLE) && start && (length != {LEN_WIDTH{1'b0}});

    // Next-state and read-issue decision.
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = (length == {LEN_WIDTH{1'b0}}) ? ST_DONE : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                issue_s = (issue_cnt_r != {LEN_WIDTH{1'b0}}) && (load_s < (3'd2 + {2'b00, pop_s}));
                if (pop_s && (pop_cnt_r == LEN_WIDTH'(1))) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, counters, read address and in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            issue_cnt_r <= {LEN_WIDTH{1'b0}};
            pop_cnt_r   <= {LEN_WIDTH{1'b0}};
            ram_addr_r  <= {ADDR_WIDTH{1'b0}};
            pend_r      <= 1'b0;
            pend_last_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            pend_r      <= issue_s;
            pend_last_r <= issue_s && (issue_cnt_r == LEN_WIDTH'(1));
            if (accept_s) begin
                ram_addr_r  <= base_addr;
                issue_cnt_r <= length;
                pop_cnt_r   <= length;
            end else begin
                if (issue_s) begin
                    ram_addr_r  <= next_addr(ram_addr_r);
                    issue_cnt_r <= issue_cnt_r - LEN_WIDTH'(1);
                end
                if (pop_s) begin
                    pop_cnt_r <= pop_cnt_r - LEN_WIDTH'(1);
                end
            end
        end
    end

    // Two-entry FIFO: head drives the stream, skid catches a word arriving under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid_r <= 1'b0;
            head_last_r  <= 1'b0;
            head_data_r  <= {DATA_WIDTH{1'b0}};
            skid_valid_r <= 1'b0;
            skid_last_r  <= 1'b0;
            skid_data_r  <= {DATA_WIDTH{1'b0}};
        end else if (pop_s) begin
            if (skid_valid_r) begin
                head_data_r  <= skid_data_r;
                head_last_r  <= skid_last_r;
                skid_valid_r <= pend_r;
                skid_data_r  <= ram_dout;
                skid_last_r  <= pend_last_r;
            end else begin
                head_valid_r <= pend_r;
                head_last_r  <= pend_r & pend_last_r;
                if (pend_r) begin
                    head_data_r <= ram_dout;
                end
            end
        end else if (pend_r) begin
            if (head_valid_r) begin
                skid_valid_r <= 1'b1;
                skid_data_r  <= ram_dout;
                skid_last_r  <= pend_last_r;
            end else begin
                head_valid_r <= 1'b1;
                head_data_r  <= ram_dout;
                head_last_r  <= pend_last_r;
            end
        end
    end

    assign busy      = (state_r == ST_RUN);
    assign done      = (state_r == ST_DONE);
    assign ram_en    = issue_s;
    assign ram_we    = 1'b0;
    assign ram_addr  = ram_addr_r;
    assign out_valid = head_valid_r;
    assign out_data  = head_data_r;
    assign out_last  = head_last_r;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: directed cycle table plus multi-cycle sequences
// against a read-first RAM model preloaded with mem[i] = i + 100.
module tb_ram_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  base_addr = 7'd0;
    logic [7:0]  length = 8'd0;
    logic        busy, done, ram_en, ram_we, out_valid, out_last;
    logic        out_ready = 1'b1;
    logic [6:0]  ram_addr;
    logic [19:0] ram_dout, out_data;

    logic        mem_init = 1'b1;
    logic        wr_en = 1'b0;
    logic [6:0]  wr_addr = 7'd0;
    logic [19:0] wr_data = 20'd0;
    logic [19:0] mem [0:127];

    int n_vec = 0;
    int n_err = 0;

    ram_stream_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_dout(ram_dout), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Read-first RAM with a second write port.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 20'(i + 100);
            ram_dout <= 20'd0;
        end else begin
            if (ram_en) ram_dout <= mem[ram_addr];
            if (wr_en) mem[wr_addr] <= wr_data;
        end
    end

    typedef struct {
        logic        st;
        logic [6:0]  b;
        logic [7:0]  l;
        logic        rdy;
        logic        e_busy, e_done, e_en;
        logic [6:0]  e_addr;
        logic        e_valid;
        logic [19:0] e_data;
        logic        e_last;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic st, input int b, input int l, input logic rdy,
                                input logic eb, input logic ed, input logic ee, input int ea,
                                input logic ev, input int edat, input logic el);
        vec_t v;
        v.st = st; v.b = 7'(b); v.l = 8'(l); v.rdy = rdy;
        v.e_busy = eb; v.e_done = ed; v.e_en = ee; v.e_addr = 7'(ea);
        v.e_valid = ev; v.e_data = 20'(edat); v.e_last = el;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // mode 0: ready=1; 1: random ready with a 10-cycle stall; 2: stray start while busy;
    // 3: other port writes 0xABCDE to address 7 in the cycle it is read.
    task automatic run_stream(input string nm, input int base, input int len, input int mode);
        int k = 0, issues = 0, base_hits = 0, bad = 0, cyc = 0;
        bit got_done = 0, hold_v = 0;
        logic [19:0] hold_d = 20'd0;
        logic hold_l = 1'b0;
        start = 1'b1; base_addr = 7'(base); length = 8'(len); out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!got_done && cyc < 1000) begin
            cyc++;
            if (mode == 1) out_ready = (cyc >= 5 && cyc < 15) ? 1'b0 : 1'($urandom_range(0, 1));
            else out_ready = 1'b1;
            if (mode == 2 && cyc == 2) begin
                start = 1'b1; base_addr = 7'(base + 50); length = 8'd5;
            end else begin
                start = 1'b0;
            end
            #1;
            if (hold_v && (!out_valid || out_data !== hold_d || out_last !== hold_l)) bad++;
            if (ram_en) begin
                issues++;
                if (int'(ram_addr) == base) base_hits++;
                if (mode == 3 && ram_addr == 7'd7) begin
                    wr_en = 1'b1; wr_addr = 7'd7; wr_data = 20'hABCDE;
                end
            end
            if (out_valid && out_ready) begin
                chk($sformatf("%s_data%0d", nm, k), 64'(out_data), 64'(100 + (base + k) % 128));
                chk($sformatf("%s_last%0d", nm, k), 64'(out_last), 64'(k == len - 1));
                k++;
            end
            if (issues - k > 2) bad++;
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
            if (done) got_done = 1;
            @(posedge clk); #1;
            wr_en = 1'b0;
        end
        start = 1'b0;
        chk({nm, "_done_seen"}, 64'(got_done), 64'd1);
        chk({nm, "_beats"}, 64'(k), 64'(len));
        chk({nm, "_issues"}, 64'(issues), 64'(len));
        chk({nm, "_base_reads"}, 64'(base_hits), 64'd1);
        chk({nm, "_hold_occ_errs"}, 64'(bad), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // base 5, length 4
        add(1, 5, 4, 1,   0,0,0,0,   0,0,0);
        add(0, 0, 0, 1,   1,0,1,5,   0,0,0);
        add(0, 0, 0, 1,   1,0,1,6,   0,0,0);
        add(0, 0, 0, 1,   1,0,1,7,   1,105,0);
        add(0, 0, 0, 1,   1,0,1,8,   1,106,0);
        add(0, 0, 0, 1,   1,0,0,9,   1,107,0);
        add(0, 0, 0, 1,   1,0,0,9,   1,108,1);
        add(0, 0, 0, 1,   0,1,0,9,   0,0,0);
        // wrap: base 126, length 4
        add(1, 126, 4, 1, 0,0,0,9,   0,0,0);
        add(0, 0, 0, 1,   1,0,1,126, 0,0,0);
        add(0, 0, 0, 1,   1,0,1,127, 0,0,0);
        add(0, 0, 0, 1,   1,0,1,0,   1,226,0);
        add(0, 0, 0, 1,   1,0,1,1,   1,227,0);
        add(0, 0, 0, 1,   1,0,0,2,   1,100,0);
        add(0, 0, 0, 1,   1,0,0,2,   1,101,1);
        add(0, 0, 0, 1,   0,1,0,2,   0,0,0);
        // length 0, then length 1 at base 20
        add(1, 50, 0, 1,  0,0,0,2,   0,0,0);
        add(0, 0, 0, 1,   0,1,0,2,   0,0,0);
        add(1, 20, 1, 1,  0,0,0,2,   0,0,0);
        add(0, 0, 0, 1,   1,0,1,20,  0,0,0);
        add(0, 0, 0, 1,   1,0,0,21,  0,0,0);
        add(0, 0, 0, 1,   1,0,0,21,  1,120,1);
        add(0, 0, 0, 1,   0,1,0,21,  0,0,0);
        add(0, 0, 0, 1,   0,0,0,21,  0,0,0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 64'({busy, done, ram_en, ram_we, ram_addr, out_valid, out_data, out_last}), 64'd0);
        rst = 1'b0;
        mem_init = 1'b0;

        foreach (tbl[i]) begin
            start = tbl[i].st; base_addr = tbl[i].b; length = tbl[i].l; out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d", i),
                64'({busy, done, ram_en, ram_we, ram_addr, out_valid,
                     tbl[i].e_valid ? out_data : 20'd0, tbl[i].e_valid ? out_last : 1'b0}),
                64'({tbl[i].e_busy, tbl[i].e_done, tbl[i].e_en, 1'b0, tbl[i].e_addr,
                     tbl[i].e_valid, tbl[i].e_data, tbl[i].e_last}));
            @(posedge clk); #1;
        end
        start = 1'b0;

        run_stream("bp", 0, 10, 1);
        run_stream("stray", 40, 3, 2);
        run_stream("full", 3, 128, 0);
        run_stream("rdfirst", 7, 1, 3);

        // reset with two words buffered under stall
        start = 1'b1; base_addr = 7'd60; length = 8'd8; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #1;
        chk("stall_full", 64'({busy, ram_en, out_valid, out_data}), 64'({1'b1, 1'b0, 1'b1, 20'd160}));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_reset", 64'({busy, done, ram_en, ram_addr, out_valid, out_data, out_last}), 64'd0);
        @(posedge clk); #1;
        chk("post_reset_no_done", 64'({busy, done, out_valid}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
